rsp_frame_engine: RTL

RSP_FRAME_ENGINE -- requirements
Module: rsp_frame_engine

---
 rtl/rsp_frame_engine.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/rsp_frame_engine.sv
// Response framer: SOF, STATUS, CMD, optional address echo and read payload, then CRC-8 (poly 0x07).
// Byte-wide TX stream with a single registered output stage and an optional inter-frame gap.
module rsp_frame_engine #(
  parameter int          MAX_PAYLOAD = 64,
  parameter int          ADDR_BYTES  = 4,
  parameter int          IFG_CYCLES  = 1,
  parameter logic [7:0]  SOF_BYTE    = 8'h5A,
  localparam int         LW          = $clog2(MAX_PAYLOAD + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [7:0]              req_status,
  input  logic [7:0]              req_cmd,
  input  logic [8*ADDR_BYTES-1:0] req_addr,
  input  logic [LW-1:0]           req_len,
  input  logic                    req_is_read,
  input  logic [7:0]              pl_data,
  input  logic                    pl_valid,
  output logic                    pl_ready,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  input  logic                    abort,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    frame_aborted,
  output logic [15:0]             frame_count
);

  localparam int ACW = $clog2(ADDR_BYTES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SOF, S_STATUS, S_CMD, S_ADDR, S_DATA, S_CRC, S_GAP
  } state_t;

  state_t                  state_q;
  logic [7:0]              tx_data_q;
  logic                    tx_valid_q;
  logic [7:0]              crc_q;
  logic [7:0]              status_q;
  logic [7:0]              cmd_q;
  logic [8*ADDR_BYTES-1:0] addr_q;
  logic [LW-1:0]           len_q;
  logic                    has_pl_q;
  logic [ACW-1:0]          addr_cnt_q;
  logic [LW-1:0]           dcnt_q;
  logic                    crc_loaded_q;
  logic [3:0]              gap_q;
  logic                    frame_done_q;
  logic                    frame_aborted_q;
  logic [15:0]             frame_count_q;

  logic tx_hs;
  logic slot_free;
  logic pl_hs;

  function automatic logic [7:0] crc8_upd(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] x;
    x = crc ^ b;
    for (int i = 0; i < 8; i++) begin
      x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
    end
    return x;
  endfunction

  assign tx_hs     = tx_valid_q && tx_ready;
  assign slot_free = !tx_valid_q || tx_ready;
  // Payload is pulled straight into the output register; an aborting cycle takes nothing.
  assign pl_ready  = (state_q == S_DATA) && slot_free && !abort;
  assign pl_hs     = pl_valid && pl_ready;

  assign req_ready     = (state_q == S_IDLE) && !rst;
  assign busy          = (state_q != S_IDLE);
  assign tx_data       = tx_data_q;
  assign tx_valid      = tx_valid_q;
  assign frame_done    = frame_done_q;
  assign frame_aborted = frame_aborted_q;
  assign frame_count   = frame_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      tx_data_q       <= 8'h00;
      tx_valid_q      <= 1'b0;
      crc_q           <= 8'h00;
      status_q        <= 8'h00;
      cmd_q           <= 8'h00;
      addr_q          <= '0;
      len_q           <= '0;
      has_pl_q        <= 1'b0;
      addr_cnt_q      <= '0;
      dcnt_q          <= '0;
      crc_loaded_q    <= 1'b0;
      gap_q           <= 4'd0;
      frame_done_q    <= 1'b0;
      frame_aborted_q <= 1'b0;
      frame_count_q   <= 16'd0;
    end else begin
      frame_done_q    <= 1'b0;
      frame_aborted_q <= 1'b0;
      if (abort && state_q != S_IDLE) begin
        state_q         <= S_IDLE;
        tx_valid_q      <= 1'b0;
        crc_q           <= 8'h00;
        frame_aborted_q <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (req_valid) begin
              status_q   <= req_status;
              cmd_q      <= req_cmd;
              addr_q     <= req_addr;
              len_q      <= (req_len > LW'(MAX_PAYLOAD)) ? LW'(MAX_PAYLOAD) : req_len;
              has_pl_q   <= (req_status == 8'h00) && req_is_read;
              crc_q      <= 8'h00;
              tx_data_q  <= SOF_BYTE;
              tx_valid_q <= 1'b1;
              state_q    <= S_SOF;
            end
          end
          S_SOF: begin
            if (tx_hs) begin
              tx_data_q <= status_q;
              crc_q     <= crc8_upd(crc_q, status_q);
              state_q   <= S_STATUS;
            end
          end
          S_STATUS: begin
            if (tx_hs) begin
              tx_data_q <= cmd_q;
              crc_q     <= crc8_upd(crc_q, cmd_q);
              state_q   <= S_CMD;
            end
          end
          S_CMD: begin
            if (tx_hs) begin
              if (has_pl_q) begin
                tx_data_q  <= addr_q[7:0];
                crc_q      <= crc8_upd(crc_q, addr_q[7:0]);
                addr_q     <= addr_q >> 8;
                addr_cnt_q <= ACW'(1);
                dcnt_q     <= '0;
                state_q    <= (ADDR_BYTES == 1 && len_q != '0) ? S_DATA : S_ADDR;
              end else begin
                tx_data_q    <= crc_q;
                crc_loaded_q <= 1'b1;
                state_q      <= S_CRC;
              end
            end
          end
          S_ADDR: begin
            // DATA is entered while the last address byte is still presented so payload follows without a bubble.
            if (tx_hs) begin
              if (addr_cnt_q == ACW'(ADDR_BYTES)) begin
                tx_data_q    <= crc_q;
                crc_loaded_q <= 1'b1;
                state_q      <= S_CRC;
              end else begin
                tx_data_q  <= addr_q[7:0];
                crc_q      <= crc8_upd(crc_q, addr_q[7:0]);
                addr_q     <= addr_q >> 8;
                addr_cnt_q <= addr_cnt_q + ACW'(1);
                if (addr_cnt_q == ACW'(ADDR_BYTES - 1) && len_q != '0) begin
                  state_q <= S_DATA;
                end
              end
            end
          end
          S_DATA: begin
            if (pl_hs) begin
              tx_data_q  <= pl_data;
              tx_valid_q <= 1'b1;
              crc_q      <= crc8_upd(crc_q, pl_data);
              dcnt_q     <= dcnt_q + LW'(1);
              if (dcnt_q == len_q - LW'(1)) begin
                crc_loaded_q <= 1'b0;
                state_q      <= S_CRC;
              end
            end else if (tx_hs) begin
              tx_valid_q <= 1'b0;
            end
          end
          S_CRC: begin
            if (!crc_loaded_q) begin
              if (slot_free) begin
                tx_data_q    <= crc_q;
                tx_valid_q   <= 1'b1;
                crc_loaded_q <= 1'b1;
              end
            end else if (tx_hs) begin
              tx_valid_q    <= 1'b0;
              frame_done_q  <= 1'b1;
              frame_count_q <= frame_count_q + 16'd1;
              gap_q         <= 4'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
              state_q       <= (IFG_CYCLES == 0) ? S_IDLE : S_GAP;
            end
          end
          S_GAP: begin
            if (gap_q == 4'd0) begin
              state_q <= S_IDLE;
            end else begin
              gap_q <= gap_q - 4'd1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule
